uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
- Byte-level command parser sitting directly downstream of uart_transceiver's receive side (rx_data/rx_done) and upstream of its transmit side (tx_data/tx_wr/tx_done).
- Decodes host frames into single-beat register-bus writes/reads.
- Returns read data over the UART.
- Used inside the uart top-level as the bridge between the serial link and on-chip registers.

Parameters:
- HEADER, 8'h12, frame start byte
- CMD_WR, 8'h56, write opcode
- CMD_RD, 8'h34, read opcode
- TIMEOUT_CYCLES, 100000, sys_clk cycles allowed between received bytes inside a frame; counter width $clog2(TIMEOUT_CYCLES+1)

Ports:
- sys_clk  in  1  system clock, all logic on rising edge
- sys_rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte, valid when rx_done=1
- rx_done  in  1  one-cycle pulse per received byte
- tx_data  out  8  byte to transmit
- tx_wr  out  1  one-cycle transmit request
- tx_done  in  1  one-cycle pulse, transmitter finished byte
- reg_addr  out  8  register address
- reg_wdata  out  8  write data
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe
- reg_rdata  in  8  read data, valid exactly 1 cycle after reg_re
- busy  out  1  high whenever state != IDLE
- frame_err  out  1  one-cycle pulse on bad opcode or timeout

Behaviour:
- Reset (sys_rst_n=0, async): state IDLE; tx_data=0, tx_wr=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, frame_err=0; internal count, timer and rdata buffer cleared. Reset mid-frame abandons the frame with no further strobes.
- Frame format: HEADER, OP, ADDR, N, then (write only) N data bytes. N=0 means no bus access.
- Write: byte k goes to ADDR+k, wrapping modulo 256. Read: device returns N bytes from ADDR+k, same wrap.
- States:
  - IDLE: rx_done with HEADER -> OPC; any other byte ignored.
  - OPC: CMD_WR or CMD_RD latched -> ADDR; any other byte -> frame_err pulse, IDLE.
  - ADDR: latch reg_addr -> LEN.
  - LEN: latch count. If N=0 -> IDLE (or ACK, see feature). Otherwise WDATA (write) or RD_REQ (read).
  - WDATA: on each rx_done: reg_wdata=byte, reg_we=1 for one cycle. Address increments the cycle after the strobe; count decrements. Last byte -> IDLE/ACK.
  - RD_REQ: reg_re=1 for one cycle -> RD_CAP.
  - RD_CAP: capture reg_rdata; tx_data=captured, tx_wr=1 for one cycle -> TX_WAIT.
  - TX_WAIT: on tx_done, decrement count and increment address. count 0 -> IDLE, else RD_REQ.
- Latency:
  - reg_we asserts the cycle after the rx_done carrying the data byte.
  - reg_re asserts the cycle after LEN is received, or the cycle after tx_done.
  - tx_wr asserts 2 cycles after reg_re.
- Timeout: in OPC/ADDR/LEN/WDATA the timer counts cycles since the last rx_done. Reaching TIMEOUT_CYCLES -> frame_err pulse, IDLE. Timer reloads on every rx_done; inactive in IDLE and read/transmit states.
- rx_done during RD_REQ/RD_CAP/TX_WAIT is discarded; it does not restart parsing.
- rx_done and timeout in the same cycle: the byte wins and the timer reloads.
- reg_we and reg_re are never asserted together. tx_wr is never reasserted before tx_done.

Optional Feature:
- Macro UART_CMD_ACK_EN.
- Defined: on completion of a write frame (including N=0), enter ACK. ACK drives tx_data=8'hA5 with a one-cycle tx_wr, waits for tx_done, then -> IDLE. busy stays high throughout. Read frames send no ACK.
- Undefined: ACK state and logic absent; write frames return directly to IDLE; no bytes are transmitted on writes.

Test Plan:
- Write: rx 12 56 01 03 AA BB CC -> reg_we pulses with (addr,data) = (01,AA), (02,BB), (03,CC); busy low afterwards; no tx_wr (macro off).
- Read: rx 12 34 FE 03, reg_rdata=addr^8'hFF -> reg_re at FE, FF, 00 (wrap); tx bytes 01, 00, FF, each tx_wr only after the previous tx_done.
- Bad opcode: rx 12 77 01 -> frame_err pulse after 77; 01 ignored; next frame 12 56 05 01 09 writes 09 to 05.
- Timeout: TIMEOUT_CYCLES=50, rx 12 56 then silence -> frame_err exactly 50 cycles after last rx_done, state IDLE; byte 01 after timeout ignored.
- Reset mid-read: N=4, deassert sys_rst_n during TX_WAIT of byte 2 -> all outputs 0 immediately; no further reg_re/tx_wr.
- UART_CMD_ACK_EN defined: rx 12 56 10 00 -> no reg_we; tx byte A5 sent once; busy falls after tx_done.

Source files
------------

// File: rtl/uart_cmd_parser_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_parser_if
// Brief    : UART byte stream plus register bus bundle for uart_cmd_parser.
// Revision : 1.0
// ============================================================================
interface uart_cmd_parser_if;
    // UART receive/transmit side
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_done;

    // Register bus side
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;

    // Status
    logic       busy;
    logic       frame_err;

    modport master (
        input  rx_data, rx_done, tx_done, reg_rdata,
        output tx_data, tx_wr, reg_addr, reg_wdata, reg_we, reg_re, busy, frame_err
    );

    modport slave (
        output rx_data, rx_done, tx_done, reg_rdata,
        input  tx_data, tx_wr, reg_addr, reg_wdata, reg_we, reg_re, busy, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_parser
// Brief    : Decodes HEADER/OP/ADDR/N[/data] UART frames into single-beat
//            register writes and reads; read data is returned over the UART.
//            Optional write acknowledge byte enabled by macro UART_CMD_ACK_EN.
// Revision : 1.0
// ============================================================================
module uart_cmd_parser #(
    parameter logic [7:0]  HEADER         = 8'h12,
    parameter logic [7:0]  CMD_WR         = 8'h56,
    parameter logic [7:0]  CMD_RD         = 8'h34,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    uart_cmd_parser_if.master  bus
);
    localparam int unsigned     c_TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TW-1:0] c_TONE  = c_TW'(1);
    localparam logic [c_TW-1:0] c_TLAST = c_TW'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] c_IDLE    = 4'd0;
    localparam logic [3:0] c_OPC     = 4'd1;
    localparam logic [3:0] c_ADDR    = 4'd2;
    localparam logic [3:0] c_LEN     = 4'd3;
    localparam logic [3:0] c_WDATA   = 4'd4;
    localparam logic [3:0] c_RD_REQ  = 4'd5;
    localparam logic [3:0] c_RD_CAP  = 4'd6;
    localparam logic [3:0] c_TX_WAIT = 4'd7;
`ifdef UART_CMD_ACK_EN
    localparam logic [3:0] c_ACK      = 4'd8;
    localparam logic [7:0] c_ACK_BYTE = 8'hA5;
`endif

    logic [3:0]      r_state;
    logic            r_is_rd;
    logic [7:0]      r_count;
    logic [c_TW-1:0] r_timer;
    logic [7:0]      r_tx_data;
    logic            r_tx_wr;
    logic [7:0]      r_addr;
    logic [7:0]      r_wdata;
    logic            r_we;
    logic            r_re;
    logic            r_frame_err;

    logic            w_timed;
    logic            w_start;
    logic            w_timeout;

    // Inter-byte timer only runs while a frame is still being received
    assign w_timed   = (r_state == c_OPC) || (r_state == c_ADDR) ||
                       (r_state == c_LEN) || (r_state == c_WDATA);
    assign w_start   = (r_state == c_IDLE) && bus.rx_done && (bus.rx_data == HEADER);
    assign w_timeout = w_timed && !bus.rx_done && (r_timer >= c_TLAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_timer <= '0;
        end else if (!w_timed) begin
            r_timer <= w_start ? c_TONE : '0;
        end else if (bus.rx_done) begin
            r_timer <= c_TONE;
        end else begin
            r_timer <= r_timer + c_TONE;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= c_IDLE;
            r_is_rd     <= 1'b0;
            r_count     <= 8'd0;
            r_tx_data   <= 8'd0;
            r_tx_wr     <= 1'b0;
            r_addr      <= 8'd0;
            r_wdata     <= 8'd0;
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_tx_wr     <= 1'b0;
            r_frame_err <= 1'b0;

            // Write address advances once its strobe has been presented
            if (r_we) begin
                r_addr <= r_addr + 8'd1;
            end

            case (r_state)
                c_IDLE: begin
                    if (w_start) begin
                        r_state <= c_OPC;
                    end
                end

                c_OPC: begin
                    if (bus.rx_done) begin
                        if (bus.rx_data == CMD_WR) begin
                            r_is_rd <= 1'b0;
                            r_state <= c_ADDR;
                        end else if (bus.rx_data == CMD_RD) begin
                            r_is_rd <= 1'b1;
                            r_state <= c_ADDR;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= c_IDLE;
                        end
                    end else if (w_timeout) begin
                        r_frame_err <= 1'b1;
                        r_state     <= c_IDLE;
                    end
                end

                c_ADDR: begin
                    if (bus.rx_done) begin
                        r_addr  <= bus.rx_data;
                        r_state <= c_LEN;
                    end else if (w_timeout) begin
                        r_frame_err <= 1'b1;
                        r_state     <= c_IDLE;
                    end
                end

                c_LEN: begin
                    if (bus.rx_done) begin
                        r_count <= bus.rx_data;
                        if (bus.rx_data == 8'd0) begin
                            if (r_is_rd) begin
                                r_state <= c_IDLE;
                            end else begin
`ifdef UART_CMD_ACK_EN
                                r_state   <= c_ACK;
                                r_tx_data <= c_ACK_BYTE;
                                r_tx_wr   <= 1'b1;
`else
                                r_state   <= c_IDLE;
`endif
                            end
                        end else if (r_is_rd) begin
                            r_re    <= 1'b1;
                            r_state <= c_RD_REQ;
                        end else begin
                            r_state <= c_WDATA;
                        end
                    end else if (w_timeout) begin
                        r_frame_err <= 1'b1;
                        r_state     <= c_IDLE;
                    end
                end

                c_WDATA: begin
                    if (bus.rx_done) begin
                        r_wdata <= bus.rx_data;
                        r_we    <= 1'b1;
                        r_count <= r_count - 8'd1;
                        if (r_count == 8'd1) begin
`ifdef UART_CMD_ACK_EN
                            r_state   <= c_ACK;
                            r_tx_data <= c_ACK_BYTE;
                            r_tx_wr   <= 1'b1;
`else
                            r_state   <= c_IDLE;
`endif
                        end
                    end else if (w_timeout) begin
                        r_frame_err <= 1'b1;
                        r_state     <= c_IDLE;
                    end
                end

                // reg_re was raised on entry; read data arrives next cycle
                c_RD_REQ: begin
                    r_state <= c_RD_CAP;
                end

                c_RD_CAP: begin
                    r_tx_data <= bus.reg_rdata;
                    r_tx_wr   <= 1'b1;
                    r_state   <= c_TX_WAIT;
                end

                c_TX_WAIT: begin
                    if (bus.tx_done) begin
                        r_count <= r_count - 8'd1;
                        r_addr  <= r_addr + 8'd1;
                        if (r_count == 8'd1) begin
                            r_state <= c_IDLE;
                        end else begin
                            r_re    <= 1'b1;
                            r_state <= c_RD_REQ;
                        end
                    end
                end

`ifdef UART_CMD_ACK_EN
                c_ACK: begin
                    if (bus.tx_done) begin
                        r_state <= c_IDLE;
                    end
                end
`endif

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_data   = r_tx_data;
    assign bus.tx_wr     = r_tx_wr;
    assign bus.reg_addr  = r_addr;
    assign bus.reg_wdata = r_wdata;
    assign bus.reg_we    = r_we;
    assign bus.reg_re    = r_re;
    assign bus.busy      = (r_state != c_IDLE);
    assign bus.frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_parser
// Brief    : Frame-level self-checking bench for uart_cmd_parser.
// Revision : 1.0
// ============================================================================
module tb_uart_cmd_parser;
    localparam int unsigned c_TO  = 50;
    localparam logic [7:0]  c_HDR = 8'h12;
    localparam logic [7:0]  c_WR  = 8'h56;
    localparam logic [7:0]  c_RD  = 8'h34;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    uart_cmd_parser_if bus();

    uart_cmd_parser #(
        .HEADER         (c_HDR),
        .CMD_WR         (c_WR),
        .CMD_RD         (c_RD),
        .TIMEOUT_CYCLES (c_TO)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_we = 0, exp_re = 0, exp_tx = 0, exp_ferr = 0;
    int mon_we = 0, mon_re = 0, mon_tx = 0, mon_ferr = 0;
    logic [7:0] rd_mask;
    bit         tx_pending;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Register file model: data valid only in the cycle after reg_re
    always @(posedge sys_clk) begin
        bus.reg_rdata <= bus.reg_re ? (bus.reg_addr ^ rd_mask) : 8'($urandom);
    end

    // Strobe monitor: totals and bus-level invariants
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            tx_pending = 1'b0;
        end else begin
            if (bus.reg_we) begin
                mon_we++;
                chk("we_re_exclusive", bus.reg_re, 0);
            end
            if (bus.reg_re) mon_re++;
            if (bus.tx_wr) begin
                mon_tx++;
                chk("tx_wr_before_done", tx_pending, 0);
                tx_pending = 1'b1;
            end
            if (bus.tx_done) tx_pending = 1'b0;
            if (bus.frame_err) mon_ferr++;
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic gap();
        idle($urandom_range(0, 3));
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        tick();
        bus.rx_done = 1'b0;
        bus.rx_data = 8'($urandom);
    endtask

    // Transmitter model; optionally throws a stray HEADER byte at the parser
    task automatic finish_tx(input bit noise);
        int d;
        d = $urandom_range(1, 4);
        for (int i = 0; i < d; i++) begin
            if (noise && i == 0) begin
                bus.rx_data = c_HDR;
                bus.rx_done = 1'b1;
            end
            tick();
            bus.rx_done = 1'b0;
        end
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] d[$], input int lgap);
        int w;
        send_byte(c_HDR); gap();
        send_byte(c_WR);  gap();
        send_byte(addr);
        if (lgap >= 0) idle(lgap); else gap();
        send_byte(8'(d.size()));
        if (lgap >= 0) chk("len_beats_timeout", bus.frame_err, 0);
        if (d.size() == 0) chk("wr0_no_we", bus.reg_we, 0);
        foreach (d[k]) begin
            gap();
            send_byte(d[k]);
            chk("wr_we", bus.reg_we, 1);
            chk("wr_addr", bus.reg_addr, 8'(addr + k));
            chk("wr_data", bus.reg_wdata, d[k]);
            exp_we++;
        end
`ifdef UART_CMD_ACK_EN
        w = 0;
        while (!bus.tx_wr && w < 4) begin
            tick();
            w++;
        end
        chk("ack_tx_wr", bus.tx_wr, 1);
        chk("ack_byte", bus.tx_data, 8'hA5);
        chk("ack_busy", bus.busy, 1);
        exp_tx++;
        finish_tx(1'b0);
`else
        w = 0;
`endif
        chk("wr_end_busy", bus.busy, w[31:0] & 32'd0);
    endtask

    // hold >= 0: return in the cycle tx_wr of byte 'hold' is raised
    task automatic do_read(input logic [7:0] addr, input int n, input int hold);
        logic [7:0] a;
        send_byte(c_HDR); gap();
        send_byte(c_RD);  gap();
        send_byte(addr);  gap();
        send_byte(8'(n));
        if (n == 0) begin
            chk("rd0_busy", bus.busy, 0);
            chk("rd0_no_re", bus.reg_re, 0);
            return;
        end
        for (int k = 0; k < n; k++) begin
            a = 8'(addr + k);
            chk("rd_re", bus.reg_re, 1);
            chk("rd_addr", bus.reg_addr, a);
            exp_re++;
            tick();
            chk("rd_re_single", bus.reg_re, 0);
            tick();
            chk("rd_tx_wr", bus.tx_wr, 1);
            chk("rd_tx_data", bus.tx_data, a ^ rd_mask);
            exp_tx++;
            if (k == hold) return;
            finish_tx(1'b1);
        end
        chk("rd_end_busy", bus.busy, 0);
    endtask

    task automatic do_badop(input logic [7:0] op, input logic [7:0] junk);
        send_byte(c_HDR); gap();
        send_byte(op);
        chk("badop_ferr", bus.frame_err, 1);
        chk("badop_busy", bus.busy, 0);
        exp_ferr++;
        gap();
        send_byte(junk);
        chk("junk_ignored", bus.busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish within budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] op, junk, a;
        int sel, n, lat;

        bus.rx_data = 8'd0;
        bus.rx_done = 1'b0;
        bus.tx_done = 1'b0;
        rd_mask     = 8'hFF;

        sys_rst_n = 1'b0;
        idle(3);
        chk("rst_busy", bus.busy, 0);
        chk("rst_tx_wr", bus.tx_wr, 0);
        chk("rst_reg_we", bus.reg_we, 0);
        chk("rst_reg_re", bus.reg_re, 0);
        chk("rst_reg_addr", bus.reg_addr, 0);
        chk("rst_frame_err", bus.frame_err, 0);
        sys_rst_n = 1'b1;
        idle(2);

        q = '{8'hAA, 8'hBB, 8'hCC};
        do_write(8'h01, q, -1);
        do_read(8'hFE, 3, -1);
        do_badop(8'h77, 8'h01);
        q = '{8'h09};
        do_write(8'h05, q, -1);

        // Silence after the opcode must end the frame exactly c_TO cycles later
        send_byte(c_HDR);
        send_byte(c_WR);
        lat = -1;
        for (int i = 1; i <= int'(c_TO) + 10; i++) begin
            if (bus.frame_err) begin
                lat = i;
                break;
            end
            tick();
        end
        chk("timeout_latency", lat, c_TO);
        chk("timeout_busy", bus.busy, 0);
        exp_ferr++;
        send_byte(8'h01);
        chk("post_timeout_busy", bus.busy, 0);
        chk("post_timeout_we", bus.reg_we, 0);

        // Byte arriving on the last allowed cycle wins over the timeout
        q = '{8'h5A};
        do_write(8'h40, q, int'(c_TO) - 2);

        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 9);
            a = ($urandom_range(0, 2) == 0) ? 8'(8'hFC + $urandom_range(0, 3)) : 8'($urandom);
            if (sel <= 3) begin
                n = $urandom_range(0, 5);
                q.delete();
                repeat (n) q.push_back(8'($urandom));
                do_write(a, q, -1);
            end else if (sel <= 6) begin
                rd_mask = 8'($urandom);
                do_read(a, $urandom_range(0, 4), -1);
            end else if (sel == 7) begin
                do op = 8'($urandom); while (op == c_WR || op == c_RD);
                do junk = 8'($urandom); while (junk == c_HDR);
                do_badop(op, junk);
            end else if (sel == 8) begin
                do junk = 8'($urandom); while (junk == c_HDR);
                send_byte(junk);
                chk("idle_noise", bus.busy, 0);
            end else begin
                idle($urandom_range(0, 5));
            end
        end

        // Reset while waiting for tx_done of the second read byte
        rd_mask = 8'($urandom);
        do_read(8'h80, 4, 1);
        tick();
        #2 sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_tx_wr", bus.tx_wr, 0);
        chk("mid_rst_tx_data", bus.tx_data, 0);
        chk("mid_rst_reg_addr", bus.reg_addr, 0);
        chk("mid_rst_reg_wdata", bus.reg_wdata, 0);
        chk("mid_rst_reg_we", bus.reg_we, 0);
        chk("mid_rst_reg_re", bus.reg_re, 0);
        chk("mid_rst_frame_err", bus.frame_err, 0);
        idle(2);
        sys_rst_n = 1'b1;
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        idle(10);
        chk("post_rst_re_count", mon_re, exp_re);
        chk("post_rst_tx_count", mon_tx, exp_tx);
        chk("post_rst_busy", bus.busy, 0);

        q.delete();
        do_write(8'h10, q, -1);
        idle(3);

        chk("total_reg_we", mon_we, exp_we);
        chk("total_reg_re", mon_re, exp_re);
        chk("total_tx_wr", mon_tx, exp_tx);
        chk("total_frame_err", mon_ferr, exp_ferr);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
